display_timing: RTL and testbench
=================================

Name: display_timing

Overview:
- Raster timing generator that sits directly upstream of the display shaper stage.
- Walks the horizontal/vertical counters of a 640x480 raster, driving the 10-bit X/Y coordinates into the shaper.
- Generates HSYNC, VSYNC and data-enable, delayed by a configurable number of pixel ticks so they align with the shaper's memory-fetch and palette latency.
- Its outputs feed the shaper and the video output pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
PIPE_DELAY, 2, pixel ticks of delay applied to sync/DE outputs; legal range 1..8

Ports:
aClock  input  1  system clock
aReset  input  1  asynchronous, active-high reset
aEnable  input  1  pixel-tick enable; all state advances only when high
anOutX  output  10  current column; 0 during blanking
anOutY  output  10  current row; 0 during blanking
anOutActive  output  1  undelayed: current position is visible
anOutLineStart  output  1  undelayed: position is hCount==0 (any line)
anOutFrameStart  output  1  undelayed: position is hCount==0 and vCount==0
anOutHSync  output  1  delayed horizontal sync, polarity per SYNC_POL
anOutVSync  output  1  delayed vertical sync, polarity per SYNC_POL
anOutDataEnable  output  1  delayed anOutActive

Behaviour:
- Clock and reset: one clock, aClock. Reset is asynchronous and active-high on aReset.
- Totals: H_TOTAL = 800 and V_TOTAL = 525, both derived from the parameters. Counters hCount and vCount are each 10 bits.
- Reset values:
  - hCount = 0, vCount = 0.
  - Delay-line contents: sync at the inactive level (~SYNC_POL), DE = 0.
  - Visible outputs immediately after reset: anOutX = 0, anOutY = 0, anOutActive = 1, anOutLineStart = 1, anOutFrameStart = 1, anOutHSync = anOutVSync = ~SYNC_POL, anOutDataEnable = 0.
- Counter advance, on each aClock edge with aEnable = 1:
  - hCount increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, vCount increments; at V_TOTAL-1 it wraps to 0.
  - With aEnable = 0, all registers (counters and delay line) hold.
- Undelayed decode (combinational from the counter registers):
  - active = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
  - anOutX = active ? hCount : 0; anOutY = active ? vCount : 0. This keeps shaper memory addresses in range.
  - anOutLineStart and anOutFrameStart decode as listed under Ports.
- Raw sync:
  - hs_raw is true for hCount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vs_raw is true for vCount in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. 490..491. This spans whole lines, each starting at hCount 0.
- Delay line:
  - {hs_raw, vs_raw, active} shift through PIPE_DELAY registers, advancing only on aEnable.
  - Outputs are taken from the last stage. Sync is XNORed with SYNC_POL (asserted = SYNC_POL) before the final register.
  - Delayed outputs are registered, so they are glitch-free.
  - Latency: a position presented at tick t shows its sync/DE on tick t+PIPE_DELAY.
- Boundary conditions:
  - Frame wrap (799,524)->(0,0) happens in one tick; the frame-start pulse appears at the new (0,0).
  - Reset mid-frame: the counters and delay line clear immediately (asynchronously), and no partial sync pulse survives.
  - Deassertion is used as-is; the upstream reset synchronizer is owned elsewhere.
- Widths: all comparisons are done on 10-bit unsigned values. Totals must be ≤1024; out-of-range parameters are flagged by an elaboration-time assertion.

Decomposition:
- Shared package display_timing_pkg holds:
  - VGA_640x480 timing constants (H_*/V_* and totals).
  - The localparam helper for the counter width (10).
  - A typedef struct for {hsync, vsync, de}, shared with the shaper and output stages.
- One sub-module: sync_delay_line, a parameterized enable-gated shift register (WIDTH, DEPTH) with an asynchronous active-high reset to a per-bit reset value.

Test Plan:
- Reset then release with aEnable held high -> anOutX = 0, anOutY = 0, anOutDataEnable = 0, sync at ~SYNC_POL; anOutX reads 0,1,2,… and 639 at tick 639, then 0 from tick 640.
- Run one line -> hs_raw asserted for hCount 656..751. With PIPE_DELAY = 2, anOutHSync asserts (low) for exactly 96 ticks, starting on tick 658 after line start.
- Run to the end of line 0 -> at hCount 799 the next tick gives hCount = 0, vCount = 1, anOutLineStart = 1, anOutFrameStart = 0.
- Run a full frame -> vsync asserted for lines 490–491 (1600 ticks), DE high for exactly 640×480 ticks; after 420000 ticks anOutFrameStart = 1 again.
- aEnable toggled 1/0 every cycle -> all counts and the delayed-output timing stretch exactly 2×, and no output changes on enable-low cycles.
- aReset pulsed at hCount 700, vCount 491 (both syncs active) -> all outputs return to their reset values within the same cycle, with no residual sync pulse after release.

Source files
------------

// File: rtl/display_timing_pkg.sv
// Shared VGA 640x480 timing constants and the sync/DE bundle passed to the shaper
// and output stages.
package display_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Counter width is sized for the larger of the two totals.
  localparam int COUNT_W = $clog2((VGA_H_TOTAL > VGA_V_TOTAL) ? VGA_H_TOTAL : VGA_V_TOTAL);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

endpackage

// File: rtl/display_timing_delay.sv
// Enable-gated shift register; every stage resets asynchronously to RESET_VALUE.
module sync_delay_line #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= RESET_VALUE;
      end
    end else if (enable) begin
      stages[0] <= dataIn;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dataOut = stages[DEPTH-1];

endmodule

// File: rtl/display_timing.sv
// Raster timing generator: walks the h/v counters, decodes coordinates and
// produces sync/DE delayed to line up with the shaper's fetch latency.
module display_timing
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic               aClock,
  input  logic               aReset,
  input  logic               aEnable,
  output logic [COUNT_W-1:0] anOutX,
  output logic [COUNT_W-1:0] anOutY,
  output logic               anOutActive,
  output logic               anOutLineStart,
  output logic               anOutFrameStart,
  output logic               anOutHSync,
  output logic               anOutVSync,
  output logic               anOutDataEnable
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : gParamCheck
    $error("display_timing: totals must be <= 1024 and PIPE_DELAY within 1..8");
  end

  localparam logic [COUNT_W-1:0] H_LAST     = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST     = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_VISIBLE  = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_VISIBLE  = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] HS_FIRST   = COUNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_LAST    = COUNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VS_FIRST   = COUNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_LAST    = COUNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam sync_t              SYNC_IDLE  = '{hsync: !SYNC_POL, vsync: !SYNC_POL, de: 1'b0};

  logic [COUNT_W-1:0] hCount;
  logic [COUNT_W-1:0] vCount;
  logic               active;
  logic               hsRaw;
  logic               vsRaw;
  sync_t              rawSync;
  sync_t              delayedSync;

  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (aEnable) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  assign active = (hCount < H_VISIBLE) && (vCount < V_VISIBLE);
  assign hsRaw  = (hCount >= HS_FIRST) && (hCount <= HS_LAST);
  assign vsRaw  = (vCount >= VS_FIRST) && (vCount <= VS_LAST);

  // Blanking coordinates are forced to 0 so shaper addresses stay in range.
  assign anOutX          = active ? hCount : '0;
  assign anOutY          = active ? vCount : '0;
  assign anOutActive     = active;
  assign anOutLineStart  = (hCount == '0);
  assign anOutFrameStart = (hCount == '0) && (vCount == '0);

  // Polarity is applied on entry so every stage holds the pin level directly.
  assign rawSync.hsync = hsRaw ~^ SYNC_POL;
  assign rawSync.vsync = vsRaw ~^ SYNC_POL;
  assign rawSync.de    = active;

  sync_delay_line #(
    .WIDTH      ($bits(sync_t)),
    .DEPTH      (PIPE_DELAY),
    .RESET_VALUE(SYNC_IDLE)
  ) uDelay (
    .clock  (aClock),
    .reset  (aReset),
    .enable (aEnable),
    .dataIn (rawSync),
    .dataOut(delayedSync)
  );

  assign anOutHSync      = delayedSync.hsync;
  assign anOutVSync      = delayedSync.vsync;
  assign anOutDataEnable = delayedSync.de;

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: a VGA instance and a tiny-raster instance (active-high
// sync, deeper delay) checked against a tick-count model and constant tables.
module tb_display_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       lineStart;
    logic       frameStart;
    logic       hSync;
    logic       vSync;
    logic       de;
  } out_t;

  typedef struct {
    int hA, hF, hS, hB, vA, vF, vS, vB;
    bit pol;
    int d;
  } cfg_t;

  typedef struct {
    int   advance;
    out_t expected;
  } vec_t;

  logic aClock = 1'b0;
  logic aReset = 1'b1;
  logic aEnable = 1'b0;

  logic [9:0] vX, vY, sX, sY;
  logic vActive, vLine, vFrame, vHs, vVs, vDe;
  logic sActive, sLine, sFrame, sHs, sVs, sDe;
  out_t actVga, actSmall;

  int testsRun = 0;
  int testsFailed = 0;
  int ticks = 0;
  cfg_t cfgVga, cfgSmall;
  vec_t vectors[14];

  always #5 aClock = ~aClock;

  display_timing dutVga (
    .aClock(aClock), .aReset(aReset), .aEnable(aEnable),
    .anOutX(vX), .anOutY(vY), .anOutActive(vActive),
    .anOutLineStart(vLine), .anOutFrameStart(vFrame),
    .anOutHSync(vHs), .anOutVSync(vVs), .anOutDataEnable(vDe)
  );

  display_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) dutSmall (
    .aClock(aClock), .aReset(aReset), .aEnable(aEnable),
    .anOutX(sX), .anOutY(sY), .anOutActive(sActive),
    .anOutLineStart(sLine), .anOutFrameStart(sFrame),
    .anOutHSync(sHs), .anOutVSync(sVs), .anOutDataEnable(sDe)
  );

  assign actVga   = {vX, vY, vActive, vLine, vFrame, vHs, vVs, vDe};
  assign actSmall = {sX, sY, sActive, sLine, sFrame, sHs, sVs, sDe};

  // Expected outputs after n enabled ticks since reset, from raster arithmetic.
  function automatic out_t model(input cfg_t c, input int n);
    int hT, vT, tot, p, q, h, v;
    out_t e;
    hT = c.hA + c.hF + c.hS + c.hB;
    vT = c.vA + c.vF + c.vS + c.vB;
    tot = hT * vT;
    p = n % tot;
    h = p % hT;
    v = p / hT;
    e.active     = (h < c.hA) && (v < c.vA);
    e.x          = e.active ? 10'(h) : 10'd0;
    e.y          = e.active ? 10'(v) : 10'd0;
    e.lineStart  = (h == 0);
    e.frameStart = (p == 0);
    if (n >= c.d) begin
      q = (n - c.d) % tot;
      h = q % hT;
      v = q / hT;
      e.hSync = (h >= c.hA + c.hF && h < c.hA + c.hF + c.hS) ? c.pol : !c.pol;
      e.vSync = (v >= c.vA + c.vF && v < c.vA + c.vF + c.vS) ? c.pol : !c.pol;
      e.de    = (h < c.hA) && (v < c.vA);
    end else begin
      e.hSync = !c.pol;
      e.vSync = !c.pol;
      e.de    = 1'b0;
    end
    return e;
  endfunction

  function automatic out_t mk(input int x, input int y, input bit a, input bit ls,
                              input bit fs, input bit hs, input bit vs, input bit de);
    out_t r;
    r.x = 10'(x);
    r.y = 10'(y);
    r.active = a;
    r.lineStart = ls;
    r.frameStart = fs;
    r.hSync = hs;
    r.vSync = vs;
    r.de = de;
    return r;
  endfunction

  task automatic checkOutput(input string name, input out_t act, input out_t exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at tick %0d: got x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b, expected x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b",
               name, ticks, act.x, act.y, act.active, act.lineStart, act.frameStart,
               act.hSync, act.vSync, act.de, exp.x, exp.y, exp.active, exp.lineStart,
               exp.frameStart, exp.hSync, exp.vSync, exp.de);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkBoth(input string name);
    checkOutput({name, " vga"}, actVga, model(cfgVga, ticks));
    checkOutput({name, " small"}, actSmall, model(cfgSmall, ticks));
  endtask

  task automatic applyStimulus(input bit en, input bit rst);
    aEnable = en;
    aReset  = rst;
    @(posedge aClock);
    #1;
    if (rst) ticks = 0;
    else if (en) ticks++;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    aReset = 1'b0;
  endtask

  // Raise reset between edges: outputs must clear before any clock arrives.
  task automatic midReset(input string name);
    #3;
    aReset = 1'b1;
    #1;
    ticks = 0;
    checkBoth({name, " async clear"});
    applyStimulus(1'b1, 1'b1);
    aReset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkBoth({name, " after release"});
    end
  endtask

  initial begin
    int deCount, vsCount, hsLow, hsFirst;
    cfgVga   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2};
    cfgSmall = '{8, 2, 3, 2, 6, 1, 2, 1, 1'b1, 3};

    vectors[0]  = '{0,   mk(0,   0, 1, 1, 1, 1, 1, 0)};
    vectors[1]  = '{1,   mk(1,   0, 1, 0, 0, 1, 1, 0)};
    vectors[2]  = '{1,   mk(2,   0, 1, 0, 0, 1, 1, 1)};
    vectors[3]  = '{637, mk(639, 0, 1, 0, 0, 1, 1, 1)};
    vectors[4]  = '{1,   mk(0,   0, 0, 0, 0, 1, 1, 1)};
    vectors[5]  = '{2,   mk(0,   0, 0, 0, 0, 1, 1, 0)};
    vectors[6]  = '{15,  mk(0,   0, 0, 0, 0, 1, 1, 0)};
    vectors[7]  = '{1,   mk(0,   0, 0, 0, 0, 0, 1, 0)};
    vectors[8]  = '{95,  mk(0,   0, 0, 0, 0, 0, 1, 0)};
    vectors[9]  = '{1,   mk(0,   0, 0, 0, 0, 1, 1, 0)};
    vectors[10] = '{45,  mk(0,   0, 0, 0, 0, 1, 1, 0)};
    vectors[11] = '{1,   mk(0,   1, 1, 1, 0, 1, 1, 0)};
    vectors[12] = '{2,   mk(2,   1, 1, 0, 0, 1, 1, 1)};
    vectors[13] = '{798, mk(0,   2, 1, 1, 0, 1, 1, 0)};

    doReset();
    for (int i = 0; i < 14; i++) begin
      repeat (vectors[i].advance) applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("table[%0d]", i), actVga, vectors[i].expected);
    end

    // One VGA line: hsync low for exactly 96 ticks, first seen on tick 658.
    doReset();
    hsLow = 0;
    hsFirst = -1;
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (vHs == 1'b0) begin
        hsLow++;
        if (hsFirst < 0) hsFirst = ticks;
      end
    end
    checkCount("vga hsync width", hsLow, 96);
    checkCount("vga hsync start", hsFirst, 658);

    // One full small frame: DE and vsync totals, then frame start again.
    doReset();
    deCount = 0;
    vsCount = 0;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkBoth("frame run");
      if (sDe == 1'b1) deCount++;
      if (sVs == 1'b1) vsCount++;
    end
    checkCount("small de ticks", deCount, 48);
    checkCount("small vsync ticks", vsCount, 30);
    checkCount("small frame start", int'(sFrame), 1);

    // Half-rate enable: everything stretches 2x and holds on idle cycles.
    doReset();
    for (int i = 0; i < 320; i++) begin
      applyStimulus(i % 2 == 0, 1'b0);
      checkBoth("half rate");
    end

    // Reset while the small raster has both syncs asserted.
    doReset();
    repeat (7 * 15 + 11 + 3) begin
      applyStimulus(1'b1, 1'b0);
      checkBoth("approach small sync");
    end
    checkCount("small both syncs before reset", int'({sHs, sVs}), 3);
    midReset("small mid-sync reset");

    // Reset at VGA hCount 700 while hsync is asserted.
    doReset();
    repeat (700) applyStimulus(1'b1, 1'b0);
    checkOutput("vga h700", actVga, mk(0, 0, 0, 0, 0, 0, 1, 0));
    midReset("vga mid-line reset");

    // Random enable pattern with rare resets.
    doReset();
    for (int i = 0; i < 20000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4999) == 0);
      checkBoth("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
